// File: rtl/shiyan15_univ_shift_pkg.sv
// Shared constants for the universal shift register: the 2-bit mode-select encodings.
package shiyan15_univ_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shiyan15_univ_shift.sv
// 74x194-style universal shift register: hold / shift right / shift left / parallel load,
// with an active-low output enable that tri-states the parallel output.
module shiyan15_univ_shift
    import shiyan15_univ_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             oe,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    // Shifts zero-fill the vacated end so repeated shifts drain to zero rather than wrap.
    always_comb begin
        r_d = r_q;
        case (s)
            MODE_SHR:  r_d = {1'b0, r_q[WIDTH-1:1]};
            MODE_SHL:  r_d = {r_q[WIDTH-2:0], 1'b0};
            MODE_LOAD: r_d = d;
            default:   r_d = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // The output enable only gates the bus driver; the register keeps operating underneath.
    assign q = oe ? {WIDTH{1'bz}} : r_q;

endmodule

// File: tb/tb_shiyan15_univ_shift.sv
// Self-checking bench for shiyan15_univ_shift (WIDTH=4): a reference model pushes expected
// register values into a scoreboard queue as stimulus is driven; they are popped after each edge.
module tb_shiyan15_univ_shift;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             oe;
    logic [1:0]       s;
    logic [WIDTH-1:0] d;
    wire  [WIDTH-1:0] q;
    logic             qIsZ;

    int               vectorsApplied;
    int               miscompares;
    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] expectQ[$];

    shiyan15_univ_shift #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .oe    (oe),
        .s     (s),
        .d     (d),
        .q     (q)
    );

    assign qIsZ = (q === 4'bzzzz);

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one mode on the falling edge, predicts the register with an independent model,
    // then pops the prediction after the rising edge and compares it against the bus.
    task automatic applyStimulus(input string tag, input logic [1:0] mode, input logic [WIDTH-1:0] data, input logic outEn);
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        s  = mode;
        d  = data;
        oe = outEn;
        case (mode)
            2'b01:   model = model >> 1;
            2'b10:   model = model << 1;
            2'b11:   model = data;
            default: model = model;
        endcase
        expectQ.push_back(model);
        @(posedge clk);
        #1;
        if (expectQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = expectQ.pop_front();
            if (outEn) begin
                checkOutput({tag, "_z"}, {31'd0, qIsZ}, 32'd1);
            end else begin
                checkOutput(tag, {28'd0, q}, {28'd0, exp});
            end
        end
    endtask

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        model          = '0;
        rst_n = 1'b0;
        oe    = 1'b0;
        s     = 2'b00;
        d     = '0;

        // Asynchronous reset is visible before any clock edge.
        #2;
        checkOutput("reset_noclk", {28'd0, q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("hold0_a", 2'b00, 4'h0, 1'b0);
        applyStimulus("hold0_b", 2'b00, 4'h0, 1'b0);

        // Load while the output is disabled, then re-enable.
        applyStimulus("load4_oe1", 2'b11, 4'h4, 1'b1);
        oe = 1'b0;
        #1;
        checkOutput("load4_oe0", {28'd0, q}, 32'h4);

        applyStimulus("shr_1", 2'b01, 4'h0, 1'b0);
        applyStimulus("shr_2", 2'b01, 4'h0, 1'b0);
        applyStimulus("shr_3", 2'b01, 4'h0, 1'b0);
        applyStimulus("shr_drain1", 2'b01, 4'h0, 1'b0);
        applyStimulus("shr_drain2", 2'b01, 4'h0, 1'b0);

        applyStimulus("load3", 2'b11, 4'h3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("shl_%0d", i), 2'b10, 4'h0, 1'b0);
        end

        applyStimulus("loadA", 2'b11, 4'hA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("holdA_%0d", i), 2'b00, 4'h5, 1'b0);
        end

        // Mode/data change during the high phase must not disturb the register.
        #1;
        s = 2'b11;
        d = 4'h5;
        #1;
        checkOutput("midcycle_a", {28'd0, q}, 32'hA);
        @(negedge clk);
        checkOutput("midcycle_b", {28'd0, q}, 32'hA);
        applyStimulus("midcycle_load", 2'b11, 4'h5, 1'b0);

        // Reset pulse between edges clears at once; the next edge loads normally.
        applyStimulus("loadF", 2'b11, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_pulse", {28'd0, q}, 32'd0);
        model = '0;
        #1;
        rst_n = 1'b1;
        applyStimulus("load9", 2'b11, 4'h9, 1'b0);

        // Shifting continues while the output is disabled.
        applyStimulus("shl_oe1", 2'b10, 4'h0, 1'b1);
        applyStimulus("hold_oe0", 2'b00, 4'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rand_%0d", i), 2'($urandom_range(3)), 4'($urandom_range(15)),
                          ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
